whack_target_ctrl: RTL and testbench

Parametrised multi-target reaction-game controller. The controller lights one of `N_TGT` targets at a time, chosen pseudo-randomly, and holds it for a fixed window. It scores a hit when the matching button rises inside that window, and counts a miss on timeout. It drives a thermometer LED bar from the score and ends the round on a score or miss limit. It sits between the raw board buttons/LEDs and the top-level game wrapper.

---
 rtl/whack_pkg.sv | 27 ++
 rtl/whack_target_ctrl_btn_sync_edge.sv | 41 ++++
 rtl/whack_target_ctrl.sv | 171 +++++++++++++++++
 tb/tb_whack_target_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared state encoding and LFSR constants for whack_target_ctrl
//
// Contents:
//   whack_state_e  controller states (IDLE, OFF, ON, DONE)
//   LFSR_W         LFSR width (8)
//   LFSR_TAPS      feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   lfsr_next()    one Fibonacci shift step
package whack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OFF  = 2'd1,
    ST_ON   = 2'd2,
    ST_DONE = 2'd3
  } whack_state_e;

  localparam int LFSR_W = 8;

  // Polynomial terms x^8, x^6, x^5, x^4 map to register bits 7, 5, 4, 3.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  // Shift left, feedback enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/whack_target_ctrl_btn_sync_edge.sv
// rtl/whack_target_ctrl_btn_sync_edge.sv - per-channel 2-flop synchronizer and rising-edge detector
//
// Module btn_sync_edge
//   W      channel count
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset, all flops clear to 0
//   din    in  W  asynchronous raw inputs
//   rise   out W  one-cycle high when a synchronized channel goes 0 -> 1
module btn_sync_edge
  import whack_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta;
  logic [W-1:0] sync;
  logic [W-1:0] sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= '0;
      sync   <= '0;
      sync_d <= '0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  // Decoded straight from flops so the edge is seen in the cycle after
  // the second synchronizer stage captures it.
  assign rise = sync & ~sync_d;

endmodule

// File: rtl/whack_target_ctrl.sv
// rtl/whack_target_ctrl.sv - multi-target reaction-game controller
//
// Optional feature macro: WHACK_PENALTY_EN (wrong-button edge during ON counts as a miss)
//
// Ports:
//   clk        in  1        system clock, rising edge
//   rst_n      in  1        asynchronous active-low reset
//   start      in  1        starts a round from IDLE or DONE
//   btn        in  N_TGT    raw buttons, active-high, asynchronous
//   tgt        out N_TGT    one-hot lit target, zero when dark
//   score      out SCORE_W  hits this round
//   miss_cnt   out SCORE_W  misses this round
//   hit        out 1        one-cycle pulse per hit
//   miss       out 1        one-cycle pulse per miss
//   led        out LED_N    thermometer of score, led[i] = score > i
//   game_over  out 1        high while in DONE
module whack_target_ctrl
  import whack_pkg::*;
#(
  parameter int                N_TGT      = 4,
  parameter int                ON_CYCLES  = 10,
  parameter int                OFF_CYCLES = 10,
  parameter int                SCORE_W    = 4,
  parameter int                SCORE_MAX  = 6,
  parameter int                MISS_MAX   = 3,
  parameter int                LED_N      = 6,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_TGT-1:0]   btn,
  output logic [N_TGT-1:0]   tgt,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] miss_cnt,
  output logic               hit,
  output logic               miss,
  output logic [LED_N-1:0]   led,
  output logic               game_over
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] OFF  = ST_OFF;
  localparam logic [1:0] ON   = ST_ON;
  localparam logic [1:0] DONE = ST_DONE;

  localparam int SEL_W   = $clog2(N_TGT);
  localparam int TMR_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0]   ON_LAST   = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0]   OFF_LAST  = TMR_W'(OFF_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_LIM = SCORE_W'(SCORE_MAX);
  localparam logic [SCORE_W-1:0] MISS_LIM  = SCORE_W'(MISS_MAX);

  logic [1:0]         state;
  logic [TMR_W-1:0]   timer;
  logic [LFSR_W-1:0]  lfsr;
  logic [N_TGT-1:0]   rise;
  logic [SCORE_W-1:0] score_inc;
  logic [SCORE_W-1:0] miss_inc;
  logic               hit_edge;
  logic               miss_now;

  btn_sync_edge #(
    .W (N_TGT)
  ) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn),
    .rise  (rise)
  );

  assign score_inc = score + 1'b1;
  assign miss_inc  = miss_cnt + 1'b1;

  // tgt holds the one-hot of the lit index while in ON, so it doubles as
  // the selected-button mask.
  assign hit_edge = |(rise & tgt);

`ifdef WHACK_PENALTY_EN
  logic wrong_edge;
  assign wrong_edge = |(rise & ~tgt);
  assign miss_now   = wrong_edge || (timer == ON_LAST);
`else
  assign miss_now   = (timer == ON_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      lfsr      <= LFSR_SEED;
      tgt       <= '0;
      score     <= '0;
      miss_cnt  <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      led       <= '0;
      game_over <= 1'b0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      hit  <= 1'b0;
      miss <= 1'b0;

      // Follows the registered score, so it trails score by one cycle.
      for (int i = 0; i < LED_N; i++) begin
        led[i] <= (int'(score) > i);
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            score     <= '0;
            miss_cnt  <= '0;
            timer     <= '0;
            game_over <= 1'b0;
            state     <= OFF;
          end
        end

        OFF: begin
          if (timer == OFF_LAST) begin
            timer <= '0;
            tgt   <= N_TGT'(1) << lfsr[SEL_W-1:0];
            state <= ON;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ON: begin
          // Hit is tested first so it wins over a same-cycle expiry or
          // wrong-button edge.
          if (hit_edge) begin
            hit   <= 1'b1;
            score <= score_inc;
            tgt   <= '0;
            timer <= '0;
            if (score_inc == SCORE_LIM) begin
              state     <= DONE;
              game_over <= 1'b1;
            end else begin
              state <= OFF;
            end
          end else if (miss_now) begin
            miss     <= 1'b1;
            miss_cnt <= miss_inc;
            tgt      <= '0;
            timer    <= '0;
            if (miss_inc == MISS_LIM) begin
              state     <= DONE;
              game_over <= 1'b1;
            end else begin
              state <= OFF;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          tgt   <= '0;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_whack_target_ctrl.sv
// tb/tb_whack_target_ctrl.sv - scoreboard bench for whack_target_ctrl
module tb_whack_target_ctrl;

  localparam int N_TGT   = 4;
  localparam int ON_C    = 10;
  localparam int OFF_C   = 10;
  localparam int SCORE_W = 4;
  localparam int S_MAX   = 6;
  localparam int M_MAX   = 3;
  localparam int LED_N   = 6;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [N_TGT-1:0]   btn;
  logic [N_TGT-1:0]   tgt;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] miss_cnt;
  logic               hit;
  logic               miss;
  logic [LED_N-1:0]   led;
  logic               game_over;

  whack_target_ctrl #(
    .N_TGT      (N_TGT),
    .ON_CYCLES  (ON_C),
    .OFF_CYCLES (OFF_C),
    .SCORE_W    (SCORE_W),
    .SCORE_MAX  (S_MAX),
    .MISS_MAX   (M_MAX),
    .LED_N      (LED_N),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .btn       (btn),
    .tgt       (tgt),
    .score     (score),
    .miss_cnt  (miss_cnt),
    .hit       (hit),
    .miss      (miss),
    .led       (led),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges counted since reset release; edge 1 is the first one with rst_n high.
  int cyc;
  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
  end

  typedef struct {
    int               kind;   // 0 lit, 1 hit, 2 miss
    int               at;
    logic [N_TGT-1:0] tgt;
    int               score;
    int               misses;
    int               over;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks;
  int  n_fail;
  int  m_score;
  int  m_miss;
  bit  m_done;
  logic [N_TGT-1:0] prev_tgt;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference LFSR: seed stepped n-1 times gives the value seen at edge n.
  function automatic int lfsr_at(input int n);
    bit [7:0] s;
    s = 8'hA5;
    for (int i = 1; i < n; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return int'(s);
  endfunction

  function automatic int therm(input int sc);
    int t;
    t = 0;
    for (int i = 0; i < LED_N; i++) if (sc > i) t = t + (1 << i);
    return t;
  endfunction

  task automatic push_ev(input int kind, input int at, input logic [N_TGT-1:0] t,
                         input int sc, input int mi, input int ov);
    ev_t e;
    e.kind = kind; e.at = at; e.tgt = t; e.score = sc; e.misses = mi; e.over = ov;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.at);
      chk("ev_tgt", int'(tgt), int'(e.tgt));
      chk("ev_score", int'(score), e.score);
      chk("ev_miss_cnt", int'(miss_cnt), e.misses);
      chk("ev_game_over", int'(game_over), e.over);
      if (kind == 0) chk("ev_led", int'(led), therm(e.score));
    end
  endtask

  // Monitor: every DUT output event pops one expected entry.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_tgt = '0;
    end else begin
      if (tgt != '0 && prev_tgt == '0) check_event(0);
      if (hit)  check_event(1);
      if (miss) check_event(2);
      prev_tgt = tgt;
    end
  end

  task automatic step_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic start_round(output int lit_at);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_score = 0;
    m_miss  = 0;
    m_done  = 1'b0;
    lit_at  = cyc + OFF_C;
  endtask

  // act: -1 random, 0 no press, 1/2 correct press, 3 press outside window,
  // 4 wrong button, 5 correct and wrong together.
  task automatic play_target(input int lit, input int act_in, output int fin);
    int sel, act, wrong, k, is_hit;
    logic [N_TGT-1:0] one, b;
    sel = lfsr_at(lit) % N_TGT;
    one = '0;
    one[sel] = 1'b1;
    push_ev(0, lit, one, m_score, m_miss, 0);
    act   = (act_in < 0) ? int'($urandom_range(0, 5)) : act_in;
    wrong = (sel + 1 + int'($urandom_range(0, N_TGT - 2))) % N_TGT;
    b = one;
    k = -1;
    is_hit = 0;
    fin = lit + ON_C;
    if ($urandom_range(0, 3) == 0) begin
      // Stray start while dark; must be ignored.
      step_to(lit - OFF_C + 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    case (act)
      1, 2: begin
        k = lit + int'($urandom_range(0, ON_C - 1)) - 1;
        is_hit = 1;
        fin = k + 2;
      end
      3: begin
        if ($urandom_range(0, 1) == 0) k = lit - 2 - int'($urandom_range(0, 3));
        else                           k = lit + ON_C - 1;
      end
      4: begin
        k = lit + int'($urandom_range(0, ON_C - 1)) - 1;
        b = '0;
        b[wrong] = 1'b1;
`ifdef WHACK_PENALTY_EN
        fin = k + 2;
`endif
      end
      5: begin
        k = lit + int'($urandom_range(0, ON_C - 1)) - 1;
        b[wrong] = 1'b1;
        is_hit = 1;
        fin = k + 2;
      end
      default: ;
    endcase
    if (is_hit != 0) m_score++;
    else             m_miss++;
    m_done = (m_score == S_MAX) || (m_miss == M_MAX);
    push_ev(is_hit != 0 ? 1 : 2, fin, '0, m_score, m_miss, int'(m_done));
    if (k > 0) begin
      step_to(k - 1);
      btn = b;
      @(negedge clk);
      btn = '0;
    end
    step_to(fin);
  endtask

  task automatic post_done();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      btn = N_TGT'($urandom_range(1, (1 << N_TGT) - 1));
      @(negedge clk);
      btn = '0;
    end
    repeat (4) @(negedge clk);
    chk("done_game_over", int'(game_over), int'(m_done));
    chk("done_tgt", int'(tgt), 0);
    chk("done_score", int'(score), m_score);
    chk("done_miss_cnt", int'(miss_cnt), m_miss);
    chk("done_led", int'(led), therm(m_score));
  endtask

  task automatic run_round(input int act);
    int lit, fin;
    start_round(lit);
    do begin
      play_target(lit, act, fin);
      lit = fin + OFF_C;
    end while (!m_done);
    post_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int lit, fin, sel;
    logic [N_TGT-1:0] one;
    n_checks = 0;
    n_fail   = 0;
    m_score  = 0;
    m_miss   = 0;
    m_done   = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    btn      = '0;
    #22 rst_n = 1'b1;
    @(negedge clk);

    chk("rst_tgt", int'(tgt), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_miss_cnt", int'(miss_cnt), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_miss", int'(miss), 0);
    chk("rst_game_over", int'(game_over), 0);
    step_to(5);

    run_round(1);   // all hits: score limit
    run_round(0);   // all timeouts: miss limit

    // Asynchronous reset while a target is lit.
    start_round(lit);
    play_target(lit, 1, fin);
    play_target(fin + OFF_C, 1, fin);
    lit = fin + OFF_C;
    sel = lfsr_at(lit) % N_TGT;
    one = '0;
    one[sel] = 1'b1;
    push_ev(0, lit, one, m_score, m_miss, 0);
    step_to(lit + 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tgt", int'(tgt), 0);
    chk("arst_score", int'(score), 0);
    chk("arst_led", int'(led), 0);
    chk("arst_game_over", int'(game_over), 0);
    chk("arst_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    m_score = 0;
    m_miss  = 0;
    m_done  = 1'b0;
    @(negedge clk);
    step_to(8);
    chk("post_rst_idle_tgt", int'(tgt), 0);

    for (int r = 0; r < 8; r++) run_round(-1);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
